// File: rtl/stereo_pkg.sv
// Shared types and width helpers for the block-matching stereo disparity engine.
package stereo_pkg;

    typedef enum logic [0:0] {
        COST_SAD = 1'b0,
        COST_SSD = 1'b1
    } cost_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic int clog2_min1(input longint value);
        int w;
        w = 0;
        while ((64'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cost_width(input int block, input int pix_w, input cost_mode_t mode);
        longint maxpix;
        longint term;
        maxpix = (64'sd1 <<< pix_w) - 64'sd1;
        term   = (mode == COST_SSD) ? maxpix * maxpix : maxpix;
        return clog2_min1(longint'(block) * longint'(block) * term + 64'sd1);
    endfunction

    function automatic int addr_width(input int img_w, input int img_h);
        return clog2_min1(longint'(img_w) * longint'(img_h));
    endfunction

endpackage

// File: rtl/block_cost_accum.sv
// Per-pixel difference, abs/square term and running window-cost accumulator.
module block_cost_accum
    import stereo_pkg::*;
#(
    parameter int         PIX_W  = 8,
    parameter int         COST_W = 18,
    parameter cost_mode_t MODE   = COST_SSD
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              valid_in,
    input  logic [PIX_W-1:0]  left_pix_in,
    input  logic [PIX_W-1:0]  right_pix_in,
    output logic [COST_W-1:0] acc_out
);

    logic signed [PIX_W:0]   diff_s;
    logic [PIX_W-1:0]        mag_s;
    logic [2*PIX_W-1:0]      sq_s;
    logic [COST_W-1:0]       term_s;
    logic [COST_W-1:0]       acc_d;
    logic [COST_W-1:0]       acc_q;

    // Signed difference folded to a magnitude; |L-R| always fits in PIX_W bits.
    always_comb begin
        diff_s = $signed({1'b0, left_pix_in}) - $signed({1'b0, right_pix_in});
        if (diff_s[PIX_W]) begin
            mag_s = PIX_W'(-diff_s);
        end else begin
            mag_s = diff_s[PIX_W-1:0];
        end
        sq_s = {{PIX_W{1'b0}}, mag_s} * {{PIX_W{1'b0}}, mag_s};
        if (MODE == COST_SSD) begin
            term_s = COST_W'(sq_s);
        end else begin
            term_s = COST_W'(mag_s);
        end
        if (clear_in) begin
            acc_d = '0;
        end else if (valid_in) begin
            acc_d = acc_q + term_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;

endmodule

// File: rtl/disparity_search_engine.sv
// Frame sweep FSM: address generation, candidate loop, best tracking and result stream.
module disparity_search_engine
    import stereo_pkg::*;
#(
    parameter int         IMG_W    = 320,
    parameter int         IMG_H    = 240,
    parameter int         BLOCK    = 6,
    parameter int         MAX_DISP = 64,
    parameter int         PIX_W    = 8,
    parameter int         RD_LAT   = 2,
    parameter cost_mode_t MODE     = COST_SSD,
    localparam int        AW       = addr_width(IMG_W, IMG_H),
    localparam int        XW       = $clog2(IMG_W),
    localparam int        YW       = $clog2(IMG_H),
    localparam int        DW       = $clog2(MAX_DISP) + 1,
    localparam int        COST_W   = cost_width(BLOCK, PIX_W, MODE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [AW-1:0]     left_addr_out,
    output logic [AW-1:0]     right_addr_out,
    input  logic [PIX_W-1:0]  left_data_in,
    input  logic [PIX_W-1:0]  right_data_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [XW-1:0]     res_x_out,
    output logic [YW-1:0]     res_y_out,
    output logic [DW-1:0]     res_disp_out,
    output logic [COST_W-1:0] res_cost_out
);

    localparam int WW = clog2_min1(BLOCK);
    localparam int LW = clog2_min1(RD_LAT);
    localparam int CW = ((XW > DW) ? XW : DW) + 1;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [DW-1:0]       d_q, d_d;
    logic [WW-1:0]       wx_q, wx_d, wy_q, wy_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]       left_addr_q, left_addr_d, right_addr_q, right_addr_d;
    logic                res_valid_q, res_valid_d;
    logic [XW-1:0]       res_x_q, res_x_d;
    logic [YW-1:0]       res_y_q, res_y_d;
    logic [DW-1:0]       res_disp_q, res_disp_d;
    logic [COST_W-1:0]   res_cost_q, res_cost_d;
    logic [COST_W-1:0]   best_cost_q, best_cost_d;
    logic [DW-1:0]       best_disp_q, best_disp_d;
    logic [COST_W-1:0]   acc_s, new_cost_s;
    logic [DW-1:0]       new_disp_s;
    logic                clear_s, last_cand_s, last_x_s, last_pos_s;
    logic [AW-1:0]       row_s;

    block_cost_accum #(
        .PIX_W  (PIX_W),
        .COST_W (COST_W),
        .MODE   (MODE)
    ) u_accum (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (clear_s),
        .valid_in     (vld_q[RD_LAT-1]),
        .left_pix_in  (left_data_in),
        .right_pix_in (right_data_in),
        .acc_out      (acc_s)
    );

    // Loop-end predicates and the candidate-vs-best decision (d=0 always wins).
    always_comb begin
        last_cand_s = (CW'(d_q) == CW'(MAX_DISP - 1)) || (CW'(d_q) == CW'(x_q));
        last_x_s    = (x_q == XW'(IMG_W - BLOCK));
        last_pos_s  = last_x_s && (y_q == YW'(IMG_H - BLOCK));
        if ((d_q == '0) || (acc_s < best_cost_q)) begin
            new_cost_s = acc_s;
            new_disp_s = d_q;
        end else begin
            new_cost_s = best_cost_q;
            new_disp_s = best_disp_q;
        end
        vld_d[0] = (state_q == ST_FETCH);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Next-state logic for the sweep FSM, counters and result register.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        d_d         = d_q;
        wx_d        = wx_q;
        wy_d        = wy_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_disp_d  = res_disp_q;
        res_cost_d  = res_cost_q;
        best_cost_d = best_cost_q;
        best_disp_d = best_disp_q;
        clear_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    d_d     = '0;
                    wx_d    = '0;
                    wy_d    = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (wx_q == WW'(BLOCK - 1)) begin
                    wx_d = '0;
                    if (wy_q == WW'(BLOCK - 1)) begin
                        wy_d    = '0;
                        lat_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        wy_d = wy_q + WW'(1);
                    end
                end else begin
                    wx_d = wx_q + WW'(1);
                end
            end
            ST_DRAIN: begin
                if (lat_q == LW'(RD_LAT - 1)) begin
                    state_d = ST_COMPARE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_COMPARE: begin
                clear_s     = 1'b1;
                best_cost_d = new_cost_s;
                best_disp_d = new_disp_s;
                if (last_cand_s) begin
                    state_d     = ST_EMIT;
                    res_valid_d = 1'b1;
                    res_x_d     = x_q;
                    res_y_d     = y_q;
                    res_disp_d  = new_disp_s;
                    res_cost_d  = new_cost_s;
                end else begin
                    d_d     = d_q + DW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (res_ready_in) begin
                    res_valid_d = 1'b0;
                    d_d         = '0;
                    if (last_pos_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (last_x_s) begin
                        x_d     = '0;
                        y_d     = y_q + YW'(1);
                        state_d = ST_FETCH;
                    end else begin
                        x_d     = x_q + XW'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Addresses are registered from next-state counters so they appear with FETCH and freeze otherwise.
    always_comb begin
        row_s = AW'(y_d) + AW'(wy_d);
        if (state_d == ST_FETCH) begin
            left_addr_d  = row_s * AW'(IMG_W) + AW'(x_d) + AW'(wx_d);
            right_addr_d = row_s * AW'(IMG_W) + AW'(x_d) - AW'(d_d) + AW'(wx_d);
        end else begin
            left_addr_d  = left_addr_q;
            right_addr_d = right_addr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            d_q          <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            lat_q        <= '0;
            vld_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            left_addr_q  <= '0;
            right_addr_q <= '0;
            res_valid_q  <= 1'b0;
            res_x_q      <= '0;
            res_y_q      <= '0;
            res_disp_q   <= '0;
            res_cost_q   <= '0;
            best_cost_q  <= '0;
            best_disp_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            d_q          <= d_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            lat_q        <= lat_d;
            vld_q        <= vld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            left_addr_q  <= left_addr_d;
            right_addr_q <= right_addr_d;
            res_valid_q  <= res_valid_d;
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
            res_disp_q   <= res_disp_d;
            res_cost_q   <= res_cost_d;
            best_cost_q  <= best_cost_d;
            best_disp_q  <= best_disp_d;
        end
    end

    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign left_addr_out  = left_addr_q;
    assign right_addr_out = right_addr_q;
    assign res_valid_out  = res_valid_q;
    assign res_x_out      = res_x_q;
    assign res_y_out      = res_y_q;
    assign res_disp_out   = res_disp_q;
    assign res_cost_out   = res_cost_q;

endmodule

// File: tb/tb_disparity_search_engine.sv
// Bench for disparity_search_engine: SSD and SAD builds on 8x4 images, 2x2 blocks, 4 candidates.
module tb_disparity_search_engine;
    import stereo_pkg::*;

    localparam int IMG_W = 8, IMG_H = 4, BLOCK = 2, MAX_DISP = 4, RD_LAT = 2;
    localparam int NPOS  = (IMG_W - BLOCK + 1) * (IMG_H - BLOCK + 1);

    logic clk_in, rst_in, start_in, res_ready_in;
    logic busy_ssd, done_ssd, valid_ssd, busy_sad, done_sad, valid_sad;
    logic [4:0] la_ssd, ra_ssd, la_sad, ra_sad;
    logic [2:0] x_ssd, x_sad, disp_ssd, disp_sad;
    logic [1:0] y_ssd, y_sad;
    logic [17:0] cost_ssd;
    logic [9:0]  cost_sad;
    logic [7:0] left_mem [32];
    logic [7:0] right_mem [32];
    logic [7:0] lp_ssd [2];
    logic [7:0] rp_ssd [2];
    logic [7:0] lp_sad [2];
    logic [7:0] rp_sad [2];

    typedef struct { int x; int y; int d_ssd; int c_ssd; int d_sad; int c_sad; } exp_t;
    exp_t exp_q[$];
    int checks = 0, failures = 0, bad_addr = 0;

    disparity_search_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK(BLOCK), .MAX_DISP(MAX_DISP),
        .PIX_W(8), .RD_LAT(RD_LAT), .MODE(COST_SSD)) u_ssd (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .busy_out(busy_ssd), .done_out(done_ssd),
        .left_addr_out(la_ssd), .right_addr_out(ra_ssd), .left_data_in(lp_ssd[1]), .right_data_in(rp_ssd[1]),
        .res_valid_out(valid_ssd), .res_ready_in(res_ready_in), .res_x_out(x_ssd), .res_y_out(y_ssd),
        .res_disp_out(disp_ssd), .res_cost_out(cost_ssd));

    disparity_search_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK(BLOCK), .MAX_DISP(MAX_DISP),
        .PIX_W(8), .RD_LAT(RD_LAT), .MODE(COST_SAD)) u_sad (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .busy_out(busy_sad), .done_out(done_sad),
        .left_addr_out(la_sad), .right_addr_out(ra_sad), .left_data_in(lp_sad[1]), .right_data_in(rp_sad[1]),
        .res_valid_out(valid_sad), .res_ready_in(res_ready_in), .res_x_out(x_sad), .res_y_out(y_sad),
        .res_disp_out(disp_sad), .res_cost_out(cost_sad));

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Two-cycle read latency frame buffers.
    always_ff @(posedge clk_in) begin
        lp_ssd[0] <= left_mem[la_ssd];  lp_ssd[1] <= lp_ssd[0];
        rp_ssd[0] <= right_mem[ra_ssd]; rp_ssd[1] <= rp_ssd[0];
        lp_sad[0] <= left_mem[la_sad];  lp_sad[1] <= lp_sad[0];
        rp_sad[0] <= right_mem[ra_sad]; rp_sad[1] <= rp_sad[0];
    end

    // Right read must be in the same row as the left read and 0..MAX_DISP-1 columns to its left.
    always @(negedge clk_in) begin
        if (busy_ssd && ((int'(la_ssd) / IMG_W != int'(ra_ssd) / IMG_W) || (ra_ssd > la_ssd) ||
                         (int'(la_ssd) - int'(ra_ssd) > MAX_DISP - 1)))
            bad_addr <= bad_addr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int x, input int y, input bit ssd, output int bd, output int bc);
        int c, dd, lim;
        bd = 0;
        bc = 0;
        lim = (x < MAX_DISP - 1) ? x : MAX_DISP - 1;
        for (int d = 0; d <= lim; d++) begin
            c = 0;
            for (int i = 0; i < BLOCK; i++)
                for (int j = 0; j < BLOCK; j++) begin
                    dd = int'(left_mem[(y + i) * IMG_W + x + j]) - int'(right_mem[(y + i) * IMG_W + x - d + j]);
                    c += ssd ? dd * dd : ((dd < 0) ? -dd : dd);
                end
            if (d == 0 || c < bc) begin
                bd = d;
                bc = c;
            end
        end
    endfunction

    task automatic run_frame(input string name, input int stall_idx, input bit shift_chk);
        exp_t e;
        int n, cyc, base, la_e, ra_e, nx;
        logic [63:0] hold_e;
        exp_q.delete();
        for (int y = 0; y <= IMG_H - BLOCK; y++)
            for (int x = 0; x <= IMG_W - BLOCK; x++) begin
                e.x = x;
                e.y = y;
                model(x, y, 1'b1, e.d_ssd, e.c_ssd);
                model(x, y, 1'b0, e.d_sad, e.c_sad);
                exp_q.push_back(e);
            end
        base = bad_addr;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        chk({name, "_start_busy"}, {busy_ssd, busy_sad}, 2'b11);
        chk({name, "_start_addr"}, {la_ssd, ra_ssd, la_sad, ra_sad}, 20'd0);
        n = 0;
        cyc = 0;
        while (n < NPOS && cyc < 5000) begin
            @(negedge clk_in);
            cyc++;
            if (valid_ssd) begin
                e = exp_q.pop_front();
                if (n == 0) chk({name, "_first_valid_cycle"}, cyc, 7);
                chk({name, "_sad_valid"}, valid_sad, 1'b1);
                chk({name, "_res_xy"}, {x_ssd, y_ssd, x_sad, y_sad}, {3'(e.x), 2'(e.y), 3'(e.x), 2'(e.y)});
                chk({name, "_ssd_disp"}, disp_ssd, e.d_ssd);
                chk({name, "_ssd_cost"}, cost_ssd, e.c_ssd);
                chk({name, "_sad_disp"}, disp_sad, e.d_sad);
                chk({name, "_sad_cost"}, cost_sad, e.c_sad);
                if (shift_chk && e.x >= 3) chk({name, "_shift_disp3"}, {disp_ssd, cost_ssd}, {3'd3, 18'd0});
                if (n == stall_idx) begin
                    res_ready_in = 1'b0;
                    la_e = (e.y + BLOCK - 1) * IMG_W + e.x + BLOCK - 1;
                    ra_e = la_e - ((e.x < MAX_DISP - 1) ? e.x : MAX_DISP - 1);
                    hold_e = {1'b1, 3'(e.x), 2'(e.y), 3'(e.d_ssd), 18'(e.c_ssd), 5'(la_e), 5'(ra_e)};
                    repeat (10) begin
                        @(negedge clk_in);
                        chk({name, "_stall_hold"}, {valid_ssd, x_ssd, y_ssd, disp_ssd, cost_ssd, la_ssd, ra_ssd}, hold_e);
                    end
                    res_ready_in = 1'b1;
                    @(posedge clk_in);
                    @(negedge clk_in);
                    nx = (e.x == IMG_W - BLOCK) ? (e.y + 1) * IMG_W : e.y * IMG_W + e.x + 1;
                    chk({name, "_after_hs_valid"}, valid_ssd, 1'b0);
                    chk({name, "_after_hs_fetch"}, {la_ssd, ra_ssd}, {5'(nx), 5'(nx)});
                end else begin
                    @(posedge clk_in);
                end
                n++;
            end
        end
        chk({name, "_result_count"}, n, NPOS);
        @(negedge clk_in);
        chk({name, "_done_pulse"}, {done_ssd, busy_ssd, done_sad, busy_sad}, 4'b1010);
        @(negedge clk_in);
        chk({name, "_done_clear"}, {done_ssd, busy_ssd, valid_ssd, done_sad}, 4'b0000);
        chk({name, "_addr_range"}, bad_addr - base, 0);
    endtask

    initial begin
        rst_in = 1'b0;
        start_in = 1'b0;
        res_ready_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            left_mem[i] = 8'd0;
            right_mem[i] = 8'd0;
        end
        repeat (3) @(negedge clk_in);
        chk("rst_ctrl", {busy_ssd, done_ssd, valid_ssd, busy_sad, done_sad, valid_sad}, 6'd0);
        chk("rst_addr", {la_ssd, ra_ssd, la_sad, ra_sad}, 20'd0);
        chk("rst_fields", {x_ssd, y_ssd, disp_ssd, cost_ssd, x_sad, y_sad, disp_sad, cost_sad}, 44'd0);
        rst_in = 1'b1;

        run_frame("flat", -1, 1'b0);

        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                left_mem[r * IMG_W + c] = 8'((7 * c * c + 13 * r + 5) % 256);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                right_mem[r * IMG_W + c] = (c + 3 < IMG_W) ? left_mem[r * IMG_W + c + 3] : 8'(200 + r);
        run_frame("shift", 1, 1'b1);

        for (int i = 0; i < 32; i++) begin
            left_mem[i] = 8'd10;
            right_mem[i] = 8'd10;
        end
        right_mem[0] = 8'd13;
        run_frame("single", -1, 1'b0);

        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        @(negedge clk_in); rst_in = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        chk("midrst_busy", {busy_ssd, busy_sad}, 2'b00);
        chk("midrst_valid", {valid_ssd, valid_sad}, 2'b00);
        chk("midrst_addr", {la_ssd, ra_ssd}, 10'd0);
        run_frame("restart", 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disparity_search_engine.md
# disparity_search_engine

Parametrised block-matching stereo disparity engine. On a start pulse it sweeps every valid block position of a rectified left/right image pair held in external pixel memories. For each position it evaluates a bounded disparity range with a selectable SAD or SSD cost and emits the best disparity and its cost through a ready/valid result stream. It sits between the left/right frame-buffer BRAMs and the disparity-result BRAM / UART readout path.

## Interface

Parameters:
- IMG_W, default 320: image width in pixels.
- IMG_H, default 240: image height in pixels.
- BLOCK, default 6: square matching-block edge, 2..8.
- MAX_DISP, default 64: number of disparity candidates, 1..IMG_W-BLOCK+1.
- PIX_W, default 8: pixel width.
- RD_LAT, default 2: fixed memory read latency in cycles (address to data).
- MODE, default COST_SSD: cost metric, COST_SAD or COST_SSD.

Ports:
- clk_in, input, 1: the single clock.
- rst_in, input, 1: reset; synchronous, active-low.
- start_in, input, 1: one-cycle pulse that begins a frame; ignored while busy_out=1.
- busy_out, output, 1: high from the cycle after an accepted start until done_out.
- done_out, output, 1: one-cycle pulse after the last result is accepted.
- left_addr_out, output, clog2(IMG_W*IMG_H): left pixel address, row*IMG_W+col.
- right_addr_out, output, clog2(IMG_W*IMG_H): right pixel address, same mapping.
- left_data_in, input, PIX_W: left pixel, valid RD_LAT cycles after its address.
- right_data_in, input, PIX_W: right pixel, same timing.
- res_valid_out, output, 1: result available.
- res_ready_in, input, 1: downstream accepts the result.
- res_x_out, output, clog2(IMG_W): block left column.
- res_y_out, output, clog2(IMG_H): block top row.
- res_disp_out, output, clog2(MAX_DISP)+1: best disparity.
- res_cost_out, output, COST_W: cost at the best disparity.

## Operation

- Positions: y from 0 to IMG_H-BLOCK (outer loop), x from 0 to IMG_W-BLOCK (inner loop), row-major.
- Candidates per position: d = 0 .. min(MAX_DISP-1, x), ascending. The left block is at (x,y); the right block is at (x-d,y). No out-of-image reads are ever issued.
- Cost is summed over the BLOCK×BLOCK window:
  - SAD: sum of |L-R|.
  - SSD: sum of (L-R)².
- Width rules: the difference is signed, PIX_W+1 bits. COST_W = clog2(BLOCK²·(2^PIX_W-1)^k + 1), with k=1 for SAD and k=2 for SSD. No overflow is possible.
- Selection: d=0 always loads best. A later d replaces best only on strictly smaller cost, so ties resolve to the smaller disparity.
- FSM states:
  - IDLE: on start_in go to FETCH with x=y=d=0.
  - FETCH: issue one left/right address pair per cycle, row-major within the window, for BLOCK² cycles, then go to DRAIN.
  - DRAIN: wait RD_LAT cycles while the final pairs accumulate, then go to COMPARE.
  - COMPARE: update best and clear the accumulator. If d is the last candidate go to EMIT; otherwise d+1 and go to FETCH.
  - EMIT: drive res_valid_out with stable fields until res_ready_in. On the handshake advance x (or wrap x to 0 and increment y) and go to FETCH with d=0. After the last position go to DONE.
  - DONE: pulse done_out, clear busy_out, go to IDLE.
- Backpressure: no reads are issued while in EMIT.
- Reset (any state, including mid-frame): the state machine and all counters clear. No partial result is ever emitted after reset.

## Timing

- Reset values: busy_out=0, done_out=0, res_valid_out=0, every address and result field 0.
- Accepted start_in → busy_out=1 and the first address pair on the next cycle.
- Per-candidate period: BLOCK²+RD_LAT+1 cycles.
- First cycle res_valid_out can be high: cand·(BLOCK²+RD_LAT+1) cycles after FETCH entry, where cand = min(MAX_DISP, x+1).
- res_valid_out rises one cycle after the last COMPARE. After a handshake the next FETCH begins on the following cycle.
- A result handshake with res_ready_in already high costs exactly 1 EMIT cycle.
- All outputs are registered.

## Structure

- Package stereo_pkg holds:
  - cost_mode_t enum {COST_SAD, COST_SSD};
  - function cost_width(BLOCK, PIX_W, MODE);
  - function addr_width(IMG_W, IMG_H).
- Sub-module block_cost_accum contains the difference, abs/square stage, and accumulator. Its controls are clear, enable, and MODE, with a delayed-valid input aligned to RD_LAT.
- The top module holds the FSM, position and disparity counters, address generation, best tracking, and the result register.

## Test plan

- Identical flat images, IMG 8×4, BLOCK 2, MAX_DISP 4 → 21 results, all disp 0 and cost 0, then one done_out pulse and busy_out=0.
- Textured left image with right = left shifted 3 columns → every result with x≥3 reports disp 3, cost 0. Results with x<3 never address a negative column.
- Single-pixel difference, L=10 vs R=13, all other pixels equal → SAD build gives cost 3, SSD build gives cost 9.
- Position x=0 with RD_LAT 2, BLOCK 2 → exactly one candidate; res_valid_out is first high 7 cycles after FETCH entry.
- res_ready_in held low 10 cycles during EMIT → res_valid_out stays high with fields stable, addresses do not change, and the next FETCH starts the cycle after the handshake.
- rst_in driven low for 1 cycle mid-FETCH → the next cycle shows busy_out=0 and res_valid_out=0. A new start_in restarts at (0,0), d=0.
